// File: rtl/dmem_arbiter.sv
// Data memory arbiter: CPU owns the 4-lane memory, a debug read port is forced
// through after MAX_WAIT cycles. Optional debug writes via DMEM_ARB_DBG_WRITE_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              sysclk,
  input  logic              cpu_resetn,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic              dbg_we,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [15:0]       dbg_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT, S_ACK} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0]   lat_addr, lat_addr_nxt;
  logic                dbg_ack_nxt;
  logic [DATA_W-1:0]   dbg_rdata_nxt;
  logic [COUNT_W-1:0]  dbg_count_nxt;

`ifdef DMEM_ARB_DBG_WRITE_EN
  logic                lat_we, lat_we_nxt;
  logic [DATA_W-1:0]   lat_wdata, lat_wdata_nxt;
`else
  logic                unused_dbg_write;
  assign unused_dbg_write = ^{dbg_we, dbg_wdata};
`endif

  // State and output registers
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      dbg_count <= '0;
`ifdef DMEM_ARB_DBG_WRITE_EN
      lat_we    <= 1'b0;
      lat_wdata <= '0;
`endif
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      lat_addr  <= lat_addr_nxt;
      dbg_ack   <= dbg_ack_nxt;
      dbg_rdata <= dbg_rdata_nxt;
      dbg_count <= dbg_count_nxt;
`ifdef DMEM_ARB_DBG_WRITE_EN
      lat_we    <= lat_we_nxt;
      lat_wdata <= lat_wdata_nxt;
`endif
    end
  end

  // Next-state logic; ack and count are set on entry to ACK so they appear together
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    lat_addr_nxt  = lat_addr;
    dbg_ack_nxt   = 1'b0;
    dbg_rdata_nxt = dbg_rdata;
    dbg_count_nxt = dbg_count;
`ifdef DMEM_ARB_DBG_WRITE_EN
    lat_we_nxt    = lat_we;
    lat_wdata_nxt = lat_wdata;
`endif
    case (state)
      S_IDLE: begin
        if (dbg_req) begin
          lat_addr_nxt = dbg_addr;
`ifdef DMEM_ARB_DBG_WRITE_EN
          lat_we_nxt    = dbg_we;
          lat_wdata_nxt = dbg_wdata;
`endif
          if (cpu_req) begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = CNT_W'(1);
          end else begin
            state_nxt = S_GRANT;
          end
        end
      end
      S_WAIT: begin
        if (!cpu_req || (wait_cnt == CNT_W'(MAX_WAIT))) begin
          state_nxt = S_GRANT;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      S_GRANT: begin
        dbg_rdata_nxt = mem_rdata;
        dbg_ack_nxt   = 1'b1;
        if (dbg_count != {COUNT_W{1'b1}}) begin
          dbg_count_nxt = dbg_count + COUNT_W'(1);
        end
        state_nxt = S_ACK;
      end
      S_ACK: begin
        wait_cnt_nxt = '0;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory port mux: debug owns the memory only during GRANT
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wren  = cpu_req ? cpu_we : 4'h0;
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    if (state == S_GRANT) begin
      mem_addr  = lat_addr;
      mem_wren  = 4'h0;
      cpu_stall = cpu_req;
`ifdef DMEM_ARB_DBG_WRITE_EN
      if (lat_we) begin
        mem_wren  = 4'hF;
        mem_wdata = lat_wdata;
      end
`endif
    end
  end

  assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cycle table, reset/write corner sequences,
// then random traffic against a timeline model of the debug access.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_DBG_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic        sysclk, cpu_resetn;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req;
  logic [7:0]  dbg_addr;
  logic        dbg_we;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_ack;
  logic [15:0] dbg_count;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wren;
  logic [31:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .sysclk(sysclk), .cpu_resetn(cpu_resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_we(dbg_we), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_count(dbg_count),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h85) return 32'h0000_0315;
    return {a, ~a, a ^ 8'hA5, 8'h3C};
  endfunction

  // Behavioural memory: write controls snapshotted just before the edge
  logic [31:0] mem [256];
  logic        do_init;
  logic [3:0]  wr_en_s;
  logic [7:0]  wr_addr_s;
  logic [31:0] wr_data_s;
  assign mem_rdata = mem[mem_addr];

  always begin
    @(negedge sysclk);
    #4;
    wr_en_s   = mem_wren;
    wr_addr_s = mem_addr;
    wr_data_s = mem_wdata;
  end

  always @(posedge sysclk) begin
    if (do_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else begin
      for (int l = 0; l < 4; l++)
        if (wr_en_s[l]) mem[wr_addr_s][8*l +: 8] <= wr_data_s[8*l +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic [3:0] cwe, input logic [7:0] caddr,
                       input logic [31:0] cwd, input logic dreq, input logic [7:0] daddr,
                       input logic dwe, input logic [31:0] dwd);
    @(negedge sysclk);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_addr = daddr; dbg_we = dwe; dbg_wdata = dwd;
    #2;
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    cpu_resetn = 1'b0; do_init = 1'b1;
    cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = 8'h3C; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_addr = '0; dbg_we = 1'b0; dbg_wdata = '0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    do_init = 1'b0;
    cpu_resetn = 1'b1;
  endtask

  typedef struct {
    logic       creq;
    logic [3:0] cwe;
    logic [7:0] caddr;
    logic       dreq;
    logic [7:0] daddr;
    logic       e_stall;
    logic       e_ack;
    logic [7:0] e_addr;
    logic [3:0] e_wren;
    logic [31:0] e_rdata;
    logic [15:0] e_count;
  } vec_t;

  // Timeline model state for the random phase
  logic [31:0] ref_mem [256];
  bit          busy;
  int          t0, grant_at, ack_at;
  logic [7:0]  m_addr;
  logic        m_we;
  logic [31:0] m_wdata, m_rdata;
  logic [15:0] m_count;

  initial begin
    vec_t vt[19];
    logic [31:0] r90, r07, r10;
    logic [7:0]  e_addr;
    logic [3:0]  e_wren;
    logic [31:0] e_wdata;
    logic        creq, dreq, dwe, is_grant, is_ack;
    logic [3:0]  cwe;
    logic [7:0]  caddr, daddr;
    logic [31:0] cwd, dwd;

    cpu_resetn = 1'b1;
    do_init = 1'b0;
    r90 = init_val(8'h90);
    r07 = init_val(8'h07);
    r10 = init_val(8'h10);

    //            creq cwe   caddr  dreq daddr  stall ack addr  wren  rdata         count
    vt[0]  = '{1'b0, 4'h0, 8'h33, 1'b1, 8'h85, 1'b0, 1'b0, 8'h33, 4'h0, 32'h0,        16'd0};
    vt[1]  = '{1'b0, 4'h0, 8'h33, 1'b1, 8'h85, 1'b0, 1'b0, 8'h85, 4'h0, 32'h0,        16'd0};
    vt[2]  = '{1'b0, 4'h0, 8'h33, 1'b1, 8'h85, 1'b0, 1'b1, 8'h33, 4'h0, 32'h315,      16'd1};
    vt[3]  = '{1'b0, 4'h0, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 4'h0, 32'h315,      16'd1};
    vt[4]  = '{1'b1, 4'h0, 8'h44, 1'b1, 8'h90, 1'b0, 1'b0, 8'h44, 4'h0, 32'h315,      16'd1};
    vt[5]  = '{1'b1, 4'h0, 8'h44, 1'b1, 8'h91, 1'b0, 1'b0, 8'h44, 4'h0, 32'h315,      16'd1};
    vt[6]  = '{1'b1, 4'h0, 8'h44, 1'b1, 8'h92, 1'b0, 1'b0, 8'h44, 4'h0, 32'h315,      16'd1};
    vt[7]  = '{1'b1, 4'h0, 8'h44, 1'b1, 8'h93, 1'b0, 1'b0, 8'h44, 4'h0, 32'h315,      16'd1};
    vt[8]  = '{1'b1, 4'h0, 8'h44, 1'b1, 8'h94, 1'b0, 1'b0, 8'h44, 4'h0, 32'h315,      16'd1};
    vt[9]  = '{1'b1, 4'h0, 8'h44, 1'b1, 8'h95, 1'b1, 1'b0, 8'h90, 4'h0, 32'h315,      16'd1};
    vt[10] = '{1'b1, 4'h0, 8'h44, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 4'h0, r90,          16'd2};
    vt[11] = '{1'b1, 4'h5, 8'h30, 1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 4'h5, r90,          16'd2};
    vt[12] = '{1'b0, 4'hF, 8'h31, 1'b0, 8'h00, 1'b0, 1'b0, 8'h31, 4'h0, r90,          16'd2};
    vt[13] = '{1'b1, 4'h0, 8'h44, 1'b1, 8'h07, 1'b0, 1'b0, 8'h44, 4'h0, r90,          16'd2};
    vt[14] = '{1'b1, 4'h0, 8'h44, 1'b1, 8'h07, 1'b0, 1'b0, 8'h44, 4'h0, r90,          16'd2};
    vt[15] = '{1'b0, 4'h0, 8'h44, 1'b1, 8'h07, 1'b0, 1'b0, 8'h44, 4'h0, r90,          16'd2};
    vt[16] = '{1'b0, 4'h0, 8'h44, 1'b1, 8'h07, 1'b0, 1'b0, 8'h07, 4'h0, r90,          16'd2};
    vt[17] = '{1'b0, 4'h0, 8'h44, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 4'h0, r07,          16'd3};
    vt[18] = '{1'b0, 4'h0, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 8'h44, 4'h0, r07,          16'd3};

    do_reset();
    cpu_resetn = 1'b0;
    #1;
    chk("reset dbg_ack", 32'(dbg_ack), 32'h0);
    chk("reset dbg_rdata", dbg_rdata, 32'h0);
    chk("reset dbg_count", 32'(dbg_count), 32'h0);
    chk("reset cpu_stall", 32'(cpu_stall), 32'h0);
    chk("reset mem_addr", 32'(mem_addr), 32'h3C);
    cpu_resetn = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].creq, vt[i].cwe, vt[i].caddr, 32'hA5A5_0000 | 32'(i),
            vt[i].dreq, vt[i].daddr, 1'b0, 32'h0);
      chk($sformatf("vec%0d stall", i), 32'(cpu_stall), 32'(vt[i].e_stall));
      chk($sformatf("vec%0d ack", i), 32'(dbg_ack), 32'(vt[i].e_ack));
      chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
      chk($sformatf("vec%0d mem_wren", i), 32'(mem_wren), 32'(vt[i].e_wren));
      chk($sformatf("vec%0d dbg_rdata", i), dbg_rdata, vt[i].e_rdata);
      chk($sformatf("vec%0d dbg_count", i), 32'(dbg_count), 32'(vt[i].e_count));
    end

    // Reset in WAIT aborts the access; the CPU store afterwards lands normally
    drive(1'b1, 4'h0, 8'h44, 32'h0, 1'b1, 8'h55, 1'b0, 32'h0);
    drive(1'b1, 4'h0, 8'h44, 32'h0, 1'b1, 8'h55, 1'b0, 32'h0);
    cpu_resetn = 1'b0;
    #1;
    chk("rst-wait dbg_ack", 32'(dbg_ack), 32'h0);
    chk("rst-wait dbg_rdata", dbg_rdata, 32'h0);
    chk("rst-wait dbg_count", 32'(dbg_count), 32'h0);
    chk("rst-wait cpu_stall", 32'(cpu_stall), 32'h0);
    repeat (2) begin
      @(negedge sysclk); #2;
      chk("rst-hold dbg_ack", 32'(dbg_ack), 32'h0);
    end
    @(negedge sysclk);
    dbg_req = 1'b0;
    cpu_resetn = 1'b1;
    drive(1'b1, 4'hF, 8'h20, 32'hCAFE_F00D, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("post-rst mem_wren", 32'(mem_wren), 32'hF);
    chk("post-rst mem_addr", 32'(mem_addr), 32'h20);
    chk("post-rst ack", 32'(dbg_ack), 32'h0);
    drive(1'b0, 4'h0, 8'h20, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("post-rst mem[20]", mem[8'h20], 32'hCAFE_F00D);
    chk("post-rst ack2", 32'(dbg_ack), 32'h0);
    chk("post-rst count", 32'(dbg_count), 32'h0);

    // Debug write then read of 0x10
    drive(1'b0, 4'h0, 8'h01, 32'h0, 1'b1, 8'h10, 1'b1, 32'hDEAD_BEEF);
    drive(1'b0, 4'h0, 8'h01, 32'h0, 1'b1, 8'h10, 1'b1, 32'hDEAD_BEEF);
    chk("dbgwr grant addr", 32'(mem_addr), 32'h10);
    chk("dbgwr grant wren", 32'(mem_wren), WR_EN ? 32'hF : 32'h0);
    if (WR_EN) chk("dbgwr grant wdata", mem_wdata, 32'hDEAD_BEEF);
    drive(1'b0, 4'h0, 8'h01, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("dbgwr ack", 32'(dbg_ack), 32'h1);
    chk("dbgwr pre-write rdata", dbg_rdata, r10);
    drive(1'b0, 4'h0, 8'h01, 32'h0, 1'b1, 8'h10, 1'b0, 32'h0);
    drive(1'b0, 4'h0, 8'h01, 32'h0, 1'b1, 8'h10, 1'b0, 32'h0);
    chk("dbgrd grant wren", 32'(mem_wren), 32'h0);
    drive(1'b0, 4'h0, 8'h01, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("dbgrd ack", 32'(dbg_ack), 32'h1);
    chk("dbgrd rdata", dbg_rdata, WR_EN ? 32'hDEAD_BEEF : r10);
    chk("dbgrd mem[10]", mem[8'h10], WR_EN ? 32'hDEAD_BEEF : r10);
    chk("dbgrd count", 32'(dbg_count), 32'h2);

    // Random traffic against the access-timeline model
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    busy = 1'b0; grant_at = -1; ack_at = -1; t0 = 0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0; m_rdata = '0; m_count = '0;
    for (int c = 0; c < 2000; c++) begin
      creq  = ($urandom_range(0, 9) < 8);
      cwe   = 4'($urandom_range(0, 15));
      caddr = 8'($urandom_range(0, 255));
      cwd   = $urandom;
      dreq  = busy ? 1'b1 : ($urandom_range(0, 2) == 0);
      daddr = 8'($urandom_range(0, 255));
      dwe   = 1'($urandom_range(0, 1));
      dwd   = $urandom;
      drive(creq, cwe, caddr, cwd, dreq, daddr, dwe, dwd);

      is_grant = (c == grant_at);
      is_ack   = (c == ack_at);
      if (is_ack && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      e_addr  = is_grant ? m_addr : caddr;
      e_wren  = is_grant ? ((WR_EN && m_we) ? 4'hF : 4'h0) : (creq ? cwe : 4'h0);
      e_wdata = (is_grant && WR_EN && m_we) ? m_wdata : cwd;

      chk($sformatf("rnd%0d stall", c), 32'(cpu_stall), 32'(is_grant & creq));
      chk($sformatf("rnd%0d ack", c), 32'(dbg_ack), 32'(is_ack));
      chk($sformatf("rnd%0d mem_addr", c), 32'(mem_addr), 32'(e_addr));
      chk($sformatf("rnd%0d mem_wren", c), 32'(mem_wren), 32'(e_wren));
      if (e_wren != 4'h0) chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, e_wdata);
      chk($sformatf("rnd%0d cpu_rdata", c), cpu_rdata, ref_mem[e_addr]);
      chk($sformatf("rnd%0d dbg_rdata", c), dbg_rdata, m_rdata);
      chk($sformatf("rnd%0d dbg_count", c), 32'(dbg_count), 32'(m_count));

      if (is_grant) m_rdata = ref_mem[m_addr];
      for (int l = 0; l < 4; l++)
        if (e_wren[l]) ref_mem[e_addr][8*l +: 8] = e_wdata[8*l +: 8];

      if (!busy && dreq) begin
        busy = 1'b1; t0 = c; grant_at = -1;
        m_addr = daddr; m_we = dwe; m_wdata = dwd;
      end
      if (busy && grant_at < 0 && (!creq || (c - t0) == MAX_WAIT)) begin
        grant_at = c + 1;
        ack_at   = c + 2;
      end
      if (is_ack) busy = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
